// File: rtl/img_pkg.sv
// Shared types and sizing for the image tile loader, inversion stage and writeback.
package img_pkg;

  localparam int NUM_WORDS  = 32;
  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 34;
  localparam int TAG_W      = 6;
  localparam int FLIT_BYTES = 16;
  localparam int IDX_W      = $clog2(NUM_WORDS);

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    START,
    RELEASE
  } loader_state_t;

endpackage

// File: rtl/tile_rsp_buffer.sv
// Tag-indexed tile storage with a valid bitmap.
// Out-of-range, duplicate and out-of-window responses set a sticky error and are dropped.
module tile_rsp_buffer
  import img_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             cap_en_i,
  input  logic             rsp_valid_i,
  input  logic [TAG_W-1:0] rsp_tag_i,
  input  word_t            rsp_data_i,
  output word_t            values_o [NUM_WORDS],
  output logic             full_o,
  output logic             err_o
);

  logic [NUM_WORDS-1:0] vld_q;
  word_t                values_q [NUM_WORDS];
  logic                 err_q;
  logic [IDX_W-1:0]     idx;
  logic                 tag_ok;
  logic                 dup;
  logic                 accept;
  logic                 bad;

  assign idx    = rsp_tag_i[IDX_W-1:0];
  assign tag_ok = (rsp_tag_i < TAG_W'(NUM_WORDS));
  assign dup    = vld_q[idx];
  assign accept = rsp_valid_i && cap_en_i && tag_ok && !dup;
  assign bad    = rsp_valid_i && !accept;

  // Valid bitmap: cleared at tile start, one bit set per first-time response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (clear_i) begin
      vld_q <= '0;
    end else if (accept) begin
      vld_q[idx] <= 1'b1;
    end
  end

  // Word storage: written only on an accepted response, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) values_q[i] <= '0;
    end else if (accept) begin
      values_q[idx] <= rsp_data_i;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bad) begin
      err_q <= 1'b1;
    end
  end

  assign values_o = values_q;
  assign full_o   = &vld_q;
  assign err_o    = err_q;

endmodule

// File: rtl/image_tile_loader.sv
// Tile loader: issues NUM_WORDS HMC reads for one tile, gathers responses by tag,
// then hands the frozen buffer to the inversion stage with a start/done handshake.
module image_tile_loader
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [TAG_W-1:0]  rd_req_tag,
  input  logic              rsp_valid,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  word_t             rsp_data,
  output word_t             tile_values [NUM_WORDS],
  output logic              start_function,
  input  logic              done_in,
  output logic              busy,
  output logic              tile_done,
  output logic              err_tag
);

  loader_state_t     state_q;
  logic [TAG_W-1:0]  cnt_q;
  logic [TAG_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] base_q;
  logic              cmd_ready_q;
  logic              rd_req_valid_q;
  logic              start_q;
  logic              busy_q;
  logic              tile_done_q;
  logic              req_fire;
  logic              buf_full;
  logic              buf_clear;
  logic              cap_en;

  assign req_fire  = rd_req_valid_q && rd_req_ready;
  assign cnt_d     = cnt_q + TAG_W'(1);
  assign buf_clear = (state_q == IDLE) && cmd_valid;
  assign cap_en    = (state_q == ISSUE) || (state_q == WAIT_RSP);

  // Main sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      base_q         <= '0;
      cmd_ready_q    <= 1'b1;
      rd_req_valid_q <= 1'b0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      tile_done_q    <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            base_q         <= cmd_addr & ~ADDR_W'(FLIT_BYTES - 1);
            cnt_q          <= '0;
            cmd_ready_q    <= 1'b0;
            rd_req_valid_q <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          if (req_fire) begin
            cnt_q <= cnt_d;
            if (cnt_q == TAG_W'(NUM_WORDS - 1)) begin
              rd_req_valid_q <= 1'b0;
              state_q        <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (buf_full) begin
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (done_in) begin
            start_q <= 1'b0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (!done_in) begin
            tile_done_q <= 1'b1;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  tile_rsp_buffer u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (buf_clear),
    .cap_en_i    (cap_en),
    .rsp_valid_i (rsp_valid),
    .rsp_tag_i   (rsp_tag),
    .rsp_data_i  (rsp_data),
    .values_o    (tile_values),
    .full_o      (buf_full),
    .err_o       (err_tag)
  );

  assign cmd_ready      = cmd_ready_q;
  assign rd_req_valid   = rd_req_valid_q;
  assign rd_req_addr    = base_q + (ADDR_W'(cnt_q) << 4);
  assign rd_req_tag     = cnt_q;
  assign start_function = start_q;
  assign busy           = busy_q;
  assign tile_done      = tile_done_q;

endmodule
